// File: rtl/lc3_trace_buffer.sv
// Instruction trace FIFO for the LC-3: captures {stamp, instruction} on every entry into FETCH.
// Define TRACE_BUFFER_OVERWRITE_EN to overwrite the oldest entry when full instead of dropping the new one.
module lc3_trace_buffer #(
    parameter int          DEPTH       = 16,
    parameter logic [5:0]  FETCH_STATE = 6'd18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [5:0]               currentState,
    input  logic [5:0]               nextState,
    input  logic [15:0]              instruction,
    input  logic                     clear,
    input  logic                     rdReady,
    output logic                     rdValid,
    output logic [31:0]              rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   stamp_q;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   mem_q [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic do_write;

    // Nested ifs so an unknown state input falls through to "no event" in simulation.
    always_comb begin
        capture = 1'b0;
        if (nextState == FETCH_STATE) begin
            if (currentState != FETCH_STATE) begin
                capture = 1'b1;
            end
        end
    end

    // Read handshake: the head entry is consumed at a rising edge where rdValid && rdReady.
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) && rdReady;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        do_write   = 1'b0;
        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (capture && (!full || pop)) begin
                do_write = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (!pop) begin
                    count_d = count_q + 1'b1;
                end
            end else if (capture) begin
                overflow_d = 1'b1;
`ifdef TRACE_BUFFER_OVERWRITE_EN
                // Full: write slot equals head slot, so both pointers step together.
                do_write = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
`endif
            end else if (pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stamp_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            stamp_q    <= stamp_q + 1'b1;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (do_write) begin
                mem_q[wr_ptr_q] <= {stamp_q, instruction};
            end
        end
    end

    assign rdValid  = (count_q != '0);
    assign rdData   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_lc3_trace_buffer.sv
// Bench for lc3_trace_buffer: directed scenarios plus long random traffic against a queue model.
module tb_lc3_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk;
    logic        reset_n;
    logic [5:0]  currentState;
    logic [5:0]  nextState;
    logic [15:0] instruction;
    logic        clear;
    logic        rdReady;
    logic        rdValid;
    logic [31:0] rdData;
    logic [4:0]  count;
    logic        overflow;

    lc3_trace_buffer #(.DEPTH(DEPTH), .FETCH_STATE(6'd18)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .currentState (currentState),
        .nextState    (nextState),
        .instruction  (instruction),
        .clear        (clear),
        .rdReady      (rdReady),
        .rdValid      (rdValid),
        .rdData       (rdData),
        .count        (count),
        .overflow     (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        m_ovf;
    logic [15:0] m_stamp;
    int          n_checks;
    int          n_pass;
    bit          chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // What one rising edge must do, stated as queue operations.
    task automatic model_edge(input logic [5:0] cur, input logic [5:0] nxt,
                              input logic [15:0] ins, input logic rdy, input logic clr);
        int  sz;
        bit  ev;
        bit  pop;
        ev = (nxt == 6'd18) && (cur != 6'd18);
        if (clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            sz  = exp_q.size();
            pop = (sz != 0) && rdy;
            if (pop) void'(exp_q.pop_front());
            if (ev) begin
                if (sz < DEPTH || pop) begin
                    exp_q.push_back({m_stamp, ins});
                end else begin
                    m_ovf = 1'b1;
`ifdef TRACE_BUFFER_OVERWRITE_EN
                    void'(exp_q.pop_front());
                    exp_q.push_back({m_stamp, ins});
`endif
                end
            end
        end
        m_stamp = m_stamp + 16'd1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdValid", 32'(rdValid), 32'(exp_q.size() != 0));
            check("count", 32'(count), 32'(exp_q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (exp_q.size() != 0) check("rdData", rdData, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [5:0] cur, input logic [5:0] nxt,
                         input logic [15:0] ins, input logic rdy, input logic clr);
        currentState = cur;
        nextState    = nxt;
        instruction  = ins;
        rdReady      = rdy;
        clear        = clr;
        @(posedge clk);
        model_edge(cur, nxt, ins, rdy, clr);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(6'd17, 6'd17, 16'h0, rdy, 1'b0);
    endtask

    task automatic event_cycle(input logic [15:0] ins, input logic rdy);
        cycle(6'd17, 6'd18, ins, rdy, 1'b0);
    endtask

    // Assert reset at a negedge, check the asynchronous effect, release one cycle later.
    task automatic apply_reset();
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_rdValid", 32'(rdValid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_rdData", rdData, 32'h0);
        exp_q.delete();
        m_ovf   = 1'b0;
        m_stamp = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
    endtask

    task automatic rand_cycle(input int rdy_pct);
        logic [5:0] cur;
        logic [5:0] nxt;
        nxt = ($urandom_range(0, 1) == 0) ? 6'd18 : 6'($urandom_range(0, 63));
        cur = ($urandom_range(0, 1) == 0) ? 6'd18 : 6'($urandom_range(0, 63));
        cycle(cur, nxt, 16'($urandom()), ($urandom_range(0, 99) < rdy_pct),
              ($urandom_range(0, 99) == 0));
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_checks     = 0;
        n_pass       = 0;
        chk_en       = 1'b0;
        reset_n      = 1'b0;
        currentState = 6'd17;
        nextState    = 6'd17;
        instruction  = 16'h0;
        clear        = 1'b0;
        rdReady      = 1'b0;
        m_ovf        = 1'b0;
        m_stamp      = 16'h0;
        @(negedge clk);
        apply_reset();

        // Capture at stamp 5 appears one cycle later.
        for (int i = 0; i < 5; i++) idle(1'b0);
        event_cycle(16'h1021, 1'b0);
        check("lit_first_data", rdData, 32'h0005_1021);
        check("lit_first_count", 32'(count), 32'd1);
        check("lit_first_valid", 32'(rdValid), 32'd1);

        // FETCH held for three cycles yields one entry.
        @(negedge clk);
        apply_reset();
        cycle(6'd17, 6'd18, 16'h1111, 1'b0, 1'b0);
        cycle(6'd18, 6'd18, 16'h2222, 1'b0, 1'b0);
        cycle(6'd18, 6'd18, 16'h3333, 1'b0, 1'b0);
        check("lit_hold_count", 32'(count), 32'd1);

        // Reset mid-operation discards entries; next capture lands fresh at stamp 0.
        apply_reset();
        event_cycle(16'hBEEF, 1'b0);
        check("lit_after_rst", rdData, 32'h0000_BEEF);

        // Seventeen events into a 16-deep FIFO with no reads.
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 17; i++) event_cycle(16'(i), 1'b0);
        check("lit_full_count", 32'(count), 32'd16);
        check("lit_full_ovf", 32'(overflow), 32'd1);
`ifdef TRACE_BUFFER_OVERWRITE_EN
        check("lit_full_head", rdData, 32'h0001_0001);
`else
        check("lit_full_head", rdData, 32'h0000_0000);
`endif

        // Clear drops overflow; then full + simultaneous push/pop keeps count.
        cycle(6'd17, 6'd17, 16'h0, 1'b0, 1'b1);
        check("lit_clear_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) event_cycle(16'h00A0 + 16'(i), 1'b0);
        event_cycle(16'h00FF, 1'b1);
        check("lit_pp_count", 32'(count), 32'd16);
        check("lit_pp_ovf", 32'(overflow), 32'd0);
        check("lit_pp_head", rdData, 32'h0013_00A1);

        // Clear wins over a coincident capture.
        cycle(6'd17, 6'd17, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) event_cycle(16'h0C00 + 16'(i), 1'b0);
        cycle(6'd17, 6'd18, 16'h0CCC, 1'b0, 1'b1);
        check("lit_clr_count", 32'(count), 32'd0);
        check("lit_clr_valid", 32'(rdValid), 32'd0);
        check("lit_clr_ovf", 32'(overflow), 32'd0);

        // Random traffic, with read pressure varied to hit empty and full alike.
        for (int i = 0; i < 3000; i++) rand_cycle((i / 250) % 2 == 0 ? 15 : 70);

        // Keep going until the stamp is about to wrap, then check stamp wraparound.
        while (m_stamp != 16'hFFFC) rand_cycle(($urandom_range(0, 3) == 0) ? 10 : 60);
        cycle(6'd17, 6'd17, 16'h0, 1'b0, 1'b1);
        idle(1'b0);
        event_cycle(16'h3000, 1'b0);
        cycle(6'd18, 6'd18, 16'h0, 1'b0, 1'b0);
        event_cycle(16'h3001, 1'b0);
        check("lit_wrap_count", 32'(count), 32'd2);
        check("lit_wrap_first", rdData, 32'hFFFE_3000);
        idle(1'b1);
        check("lit_wrap_second", rdData, 32'h0000_3001);
        idle(1'b1);
        check("lit_wrap_empty", 32'(rdValid), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_trace_buffer.md
LC3_TRACE_BUFFER -- requirements
Module: lc3_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, 2..256.
REQ-002 SHALL have parameter FETCH_STATE, default 6'd18, controller state code for FETCH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port currentState  input  6  lc3 debugCurrentState.
REQ-006 SHALL have port nextState  input  6  lc3 debugNextState.
REQ-007 SHALL have port instruction  input  16  lc3 debugInstruction.
REQ-008 SHALL have port clear  input  1  synchronous flush of FIFO and overflow flag.
REQ-009 SHALL have port rdReady  input  1  consumer accepts head entry.
REQ-010 SHALL have port rdValid  output  1  head entry present.
REQ-011 SHALL have port rdData  output  32  head entry {stamp[15:0], instruction[15:0]}.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  occupied entries.
REQ-013 SHALL have port overflow  output  1  sticky; a capture was lost or an entry was overwritten.

Function
REQ-014 SHALL keep a free-running 16-bit stamp counter: +1 every cycle, wraps 16'hFFFF->0, unaffected by clear.
REQ-015 SHALL raise a capture event in a cycle when nextState==FETCH_STATE and currentState!=FETCH_STATE; at most one event per FETCH entry.
REQ-016 SHALL on a capture event push {stamp, instruction} as sampled in that same cycle.
REQ-017 SHALL pop the head when rdValid && rdReady at a rising edge; rdReady with rdValid low has no effect.
REQ-018 SHALL drive rdValid = (count != 0), rdData = entry at read pointer, both registered-state derived, no input-to-output combinational path.
REQ-019 SHALL have one-cycle push latency: an event into an empty FIFO gives rdValid=1 the next cycle; no bypass.
REQ-020 SHALL on simultaneous push and pop at any occupancy, including full, perform both; count unchanged.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL give clear priority over push and pop: next cycle count=0, rdValid=0, overflow=0; a coincident capture is discarded.
REQ-023 SHALL leave rdData undefined-but-stable when rdValid=0; consumers ignore it.

Reset
REQ-024 SHALL, with reset_n low, asynchronously force count=0, rdValid=0, overflow=0, stamp=0, pointers=0, rdData=32'h0.
REQ-025 SHALL discard all entries when reset asserts mid-operation; first capture after release lands at index 0.
REQ-026 SHALL not capture in the first edge where reset_n has just released if currentState/nextState are X; X on those inputs SHALL be treated as no event.

Configuration
REQ-027 SHALL honour macro TRACE_BUFFER_OVERWRITE_EN.
REQ-028 SHALL, when defined, on a push into a full FIFO without pop: drop the oldest entry, advance both pointers, keep count=DEPTH, set overflow.
REQ-029 SHALL, when undefined, on a push into a full FIFO without pop: discard the new entry, leave the FIFO unchanged, set overflow.

Verification
REQ-030 Reset then nextState=18, currentState=17 for 1 cycle at stamp 5, instruction=16'h1021 -> next cycle rdValid=1, rdData=32'h0005_1021, count=1.
REQ-031 nextState=18 held for 3 cycles with currentState=18 on cycles 2-3 -> exactly one entry, count=1.
REQ-032 17 events, rdReady=0, DEPTH=16, macro undefined -> count=16, overflow=1, head holds first event; with macro defined -> count=16, overflow=1, head holds second event.
REQ-033 Full FIFO, event with rdReady=1 same cycle -> count stays 16, overflow stays 0, head advances to the next entry.
REQ-034 Three entries queued, clear and event in same cycle -> next cycle count=0, rdValid=0, overflow=0.
REQ-035 Stamp at 16'hFFFE, events on two consecutive FETCH entries 2 cycles apart -> stamps 16'hFFFE and 16'h0000.
